// File: rtl/xx03_mm_pkg.sv
// Shared types and constants for the xx03 memory-mapped initiator.
package xx03_mm_pkg;

    localparam int MM_AW       = 14;
    localparam int MM_DW       = 64;
    localparam int MM_TAG_W    = 8;
    localparam int MM_TO_CNT_W = 16;

    localparam logic [31:0] MM_TIMEOUT_PATTERN = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } mm_state_e;

endpackage

// File: rtl/xx03_mm_timeout_cnt.sv
// Read-wait watchdog: cleared while the read strobe is issued, counts each wait cycle.
// Only instantiated when XX03_MM_INIT_TIMEOUT_EN is defined.
module xx03_mm_timeout_cnt
    import xx03_mm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam logic [MM_TO_CNT_W-1:0] LAST = MM_TO_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [MM_TO_CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Expiry is only meaningful while the wait is actually running.
    assign expired = inc && (cnt_q == LAST);

endmodule

// File: rtl/xx03_pcie_mm_initiator.sv
// Single-outstanding MM master for the xx03 PCIe decoder: one strobe per command, read responses tagged.
// Read watchdog built only when XX03_MM_INIT_TIMEOUT_EN is defined.
module xx03_pcie_mm_initiator
    import xx03_mm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_wr,
    input  logic [MM_AW-1:0]    req_addr,
    input  logic [MM_DW-1:0]    req_wdata,
    input  logic [MM_TAG_W-1:0] req_tag,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MM_DW-1:0]    rsp_data,
    output logic [MM_TAG_W-1:0] rsp_tag,
    output logic                rsp_err,
    output logic                mm_wr_en,
    output logic                mm_rd_en,
    output logic [MM_AW-1:0]    mm_addr,
    output logic [MM_DW-1:0]    mm_wr_data,
    input  logic [MM_DW-1:0]    mm_rd_data,
    input  logic                mm_rd_data_v,
    output logic [15:0]         late_cnt
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("xx03_pcie_mm_initiator: TIMEOUT_CYCLES must be within 2..65535");
    end

    mm_state_e             state_q, state_d;
    logic                  req_ready_q;
    logic                  wr_q;
    logic [MM_AW-1:0]      addr_q;
    logic [MM_DW-1:0]      wdata_q;
    logic [MM_TAG_W-1:0]   tag_q;
    logic [MM_DW-1:0]      rsp_data_q;
    logic [15:0]           late_cnt_q;
    logic                  accept;
    logic                  expired;
    logic                  in_issue;
    logic                  in_wait;

    assign accept   = req_valid && req_ready_q;
    assign in_issue = (state_q == ISSUE);
    assign in_wait  = (state_q == WAIT_RD);

`ifdef XX03_MM_INIT_TIMEOUT_EN
    logic rsp_err_q;

    xx03_mm_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (in_issue),
        .inc     (in_wait),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_q <= 1'b0;
        end else if (in_wait && (mm_rd_data_v || expired)) begin
            rsp_err_q <= !mm_rd_data_v;
        end
    end

    assign rsp_err = rsp_err_q;
`else
    assign expired = 1'b0;
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = wr_q ? IDLE : WAIT_RD;
            WAIT_RD: if (mm_rd_data_v || expired) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // req_ready is registered so it reads 0 during reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= (state_d == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tag_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (accept) begin
                wr_q    <= req_wr;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                tag_q   <= req_tag;
            end
            // Real data beats the watchdog when both land in the same cycle.
            if (in_wait) begin
                if (mm_rd_data_v) begin
                    rsp_data_q <= mm_rd_data;
                end else if (expired) begin
                    rsp_data_q <= {MM_TIMEOUT_PATTERN, {(MM_DW-32-MM_AW){1'b0}}, addr_q};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            late_cnt_q <= '0;
        end else if (mm_rd_data_v && !in_wait && (late_cnt_q != 16'hFFFF)) begin
            late_cnt_q <= late_cnt_q + 16'd1;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_data   = rsp_data_q;
    assign rsp_tag    = tag_q;
    assign mm_wr_en   = in_issue && wr_q;
    assign mm_rd_en   = in_issue && !wr_q;
    assign mm_addr    = addr_q;
    assign mm_wr_data = wdata_q;
    assign late_cnt   = late_cnt_q;

endmodule

// File: doc/xx03_pcie_mm_initiator.md
# xx03_pcie_mm_initiator

Memory-mapped master that drives the `iMM_*` request side of the xx03 PCIe address decoder. It accepts single read/write commands from the PCIe TLP-handling logic over a valid/ready channel and issues exactly one single-cycle MM strobe per command. For reads, it waits for the decoder's `oMM_RD_DATA_V` and returns data plus a tag on a valid/ready response channel. A watchdog guards against a read that never completes, so the host never hangs.

## Interface
- `TIMEOUT_CYCLES`, default 1024: read-wait cycles before an error response is forced; legal range 2..65535.
- `clk`  in  1  clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `req_valid`  in  1  command valid
- `req_ready`  out  1  command accepted when valid&ready
- `req_wr`  in  1  1=write, 0=read
- `req_addr`  in  14  word address
- `req_wdata`  in  64  write data
- `req_tag`  in  8  read tag, echoed on response
- `rsp_valid`  out  1  read response valid
- `rsp_ready`  in  1  response consumed when valid&ready
- `rsp_data`  out  64  read data
- `rsp_tag`  out  8  echoed tag
- `rsp_err`  out  1  response produced by timeout
- `mm_wr_en`  out  1  to decoder `iMM_WR_EN`
- `mm_rd_en`  out  1  to decoder `iMM_RD_EN`
- `mm_addr`  out  14  to decoder `iMM_ADDR`
- `mm_wr_data`  out  64  to decoder `iMM_WR_DATA`
- `mm_rd_data`  in  64  from decoder `oMM_RD_DATA`
- `mm_rd_data_v`  in  1  from decoder `oMM_RD_DATA_V`
- `late_cnt`  out  16  saturating count of `mm_rd_data_v` pulses received outside WAIT_RD

## Operation
- States:
  - **IDLE**: `req_ready`=1. On accept, capture addr, wdata, tag and wr into registers, then go to ISSUE.
  - **ISSUE**: `mm_wr_en` or `mm_rd_en` high for exactly this one cycle.
    - Write: go to IDLE. Writes are posted and produce no response.
    - Read: go to WAIT_RD with the timeout counter cleared to 0.
  - **WAIT_RD**: the counter increments every cycle.
    - If `mm_rd_data_v`=1: capture `mm_rd_data`, set err=0, go to RESP.
    - Else, if counter == `TIMEOUT_CYCLES`-1: set data = {32'hDEAD_BEEF, 18'b0, addr}, err=1, go to RESP.
    - If data-valid and expiry fall in the same cycle, the data wins (err=0).
  - **RESP**: `rsp_valid`=1, and data, tag and err are held stable until `rsp_ready`=1, then go to IDLE.
- Only one transaction is outstanding at any time. `req_ready` is 0 in every state except IDLE.
- `mm_addr` and `mm_wr_data` hold the last captured values; they are meaningful only while a strobe is high.
- `mm_rd_data_v` seen in IDLE, ISSUE or RESP (late data after a timeout, or spurious data) is dropped and increments `late_cnt`. `late_cnt` saturates at 16'hFFFF.
- Counter width: 16 bits, no wrap-around reachable, because expiry occurs first.

## Timing
- Reset values: `req_ready`=0 during reset and 1 from the first cycle after reset in IDLE. All other outputs are 0 during reset: `rsp_valid`, `rsp_err`, `rsp_data`, `rsp_tag`, `mm_wr_en`, `mm_rd_en`, `mm_addr`, `mm_wr_data`, `late_cnt`.
- All outputs are registered or decoded directly from the state register. No combinational path exists from `req_valid` or `rsp_ready` to any output.
- Latency:
  - Accept at edge N → strobe during cycle N+1.
  - Write: `req_ready` reasserts at N+2.
  - Read: data-valid at cycle M → `rsp_valid` at M+1.
  - Timeout read: `rsp_valid` asserts `TIMEOUT_CYCLES`+1 cycles after the strobe cycle.
- Back-to-back writes therefore run at one strobe every 2 cycles.
- Reset mid-operation returns to IDLE immediately. A pending response is discarded, and no strobe is reissued.

## Configuration
- Macro: `XX03_MM_INIT_TIMEOUT_EN`.
- Defined: the watchdog behaves as described above.
- Undefined:
  - The counter logic is not built, and WAIT_RD leaves only on data-valid.
  - `rsp_err` is tied 0.
  - `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `xx03_mm_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT_RD, RESP);
  - constants `MM_AW`=14, `MM_DW`=64, `MM_TAG_W`=8;
  - `MM_TIMEOUT_PATTERN`=32'hDEAD_BEEF.
- One sub-module, `xx03_mm_timeout_cnt`, contains the clear/increment/expire counter. It is instantiated only under the macro.

## Test plan
- Write addr 14'h0010, data 64'h0123_4567_89AB_CDEF → `mm_wr_en` pulses for 1 cycle with those values; no `rsp_valid`; `req_ready` is back 2 cycles after accept.
- Read addr 14'h0020 tag 8'h5A; `mm_rd_data_v` arrives 3 cycles after `mm_rd_en` with data 64'hCAFE → next cycle `rsp_valid`=1, data 64'hCAFE, tag 8'h5A, err=0.
- Same read with `rsp_ready` held 0 for 5 cycles → response held stable; `req_ready` stays 0 until the handshake completes.
- `TIMEOUT_CYCLES`=16, read addr 14'h3FFF, no data → `rsp_err`=1, `rsp_data`=64'hDEAD_BEEF_0000_3FFF, 17 cycles after the strobe; then inject a late data-valid → `late_cnt`=1 and no response.
- Data-valid on exactly the expiry cycle → err=0 with the real data.
- Assert `rst_n` low during WAIT_RD → all outputs 0; after release, `req_ready`=1 and no stale response appears.
